// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the UART receive path.
//   rx_state_t       receiver FSM states. BRK exists only when RECV_SERIAL_FRAME_ERR_EN
//                    is defined (framing-error recovery state).
//   SERIAL_WAIT_DIV  default clk cycles per bit (100 MHz / 115200 baud).
//   SERIAL_DATA_BITS data bits per frame (8N1).
//   SERIAL_STOP_BITS stop bits per frame.
package serial_pkg;

   localparam int SERIAL_WAIT_DIV  = 868;
   localparam int SERIAL_DATA_BITS = 8;
   localparam int SERIAL_STOP_BITS = 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP
`ifdef RECV_SERIAL_FRAME_ERR_EN
      ,
      BRK
`endif
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk  in  clock
//   rst  in  synchronous active-high reset; both flops load RESET_VAL
//   d    in  asynchronous input
//   q    out synchronized output (second flop)
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/recv_serial.sv
// recv_serial: UART receiver, 8N1, LSB first, idle-high line.
// Samples each bit at its midpoint, timed by a WAIT_DIV-cycle divider that is
// re-aligned to the falling start edge of every frame.
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   data_in    in   asynchronous serial line, idle high
//   data_out   out  last received byte, held until the next valid
//   valid      out  one-cycle strobe: data_out updated this cycle
//   busy       out  high while a frame is in progress
//   frame_err  out  one-cycle strobe on a bad stop bit (only with RECV_SERIAL_FRAME_ERR_EN)
// Build option: define RECV_SERIAL_FRAME_ERR_EN to add frame_err and the BRK
// recovery state; otherwise a bad stop bit is ignored and the byte is delivered.
module recv_serial
   import serial_pkg::*;
#(
   parameter int WAIT_DIV = SERIAL_WAIT_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       busy
`ifdef RECV_SERIAL_FRAME_ERR_EN
   ,
   output logic       frame_err
`endif
);

   localparam int WAIT_LEN = $clog2(WAIT_DIV);
   localparam logic [WAIT_LEN-1:0] HALF_LAST = WAIT_LEN'(WAIT_DIV / 2 - 1);
   localparam logic [WAIT_LEN-1:0] BIT_LAST  = WAIT_LEN'(WAIT_DIV - 1);
   localparam logic [2:0]          LAST_BIT  = 3'(SERIAL_DATA_BITS - 1);

   rx_state_t           st, st_nxt;
   logic [WAIT_LEN-1:0] wait_cnt, wait_nxt;
   logic [2:0]          bit_cnt, bit_nxt;
   logic [7:0]          shift, shift_nxt;
   logic [7:0]          data_nxt;
   logic                valid_nxt;
   logic                rx_s;
`ifdef RECV_SERIAL_FRAME_ERR_EN
   logic                ferr_nxt;
`endif

   // Reset value 1 matches the idle line, so reset never looks like a start bit.
   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (data_in),
      .q   (rx_s)
   );

   assign busy = (st != IDLE);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // one unassigned and no latch is inferred.
      st_nxt    = st;
      wait_nxt  = wait_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      data_nxt  = data_out;
      valid_nxt = 1'b0;
`ifdef RECV_SERIAL_FRAME_ERR_EN
      ferr_nxt  = 1'b0;
`endif
      unique case (st)
         IDLE: begin
            if (!rx_s) begin
               st_nxt   = START;
               wait_nxt = '0;
            end
         end
         START: begin
            // Half a bit in: still low means a real start bit, and from here on
            // whole-bit waits land in the middle of each data bit.
            if (wait_cnt == HALF_LAST) begin
               wait_nxt = '0;
               if (!rx_s) begin
                  st_nxt  = DATA;
                  bit_nxt = '0;
               end else begin
                  st_nxt = IDLE;
               end
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         DATA: begin
            if (wait_cnt == BIT_LAST) begin
               shift_nxt = {rx_s, shift[7:1]};
               wait_nxt  = '0;
               if (bit_cnt == LAST_BIT) begin
                  st_nxt = STOP;
               end else begin
                  bit_nxt = bit_cnt + 3'd1;
               end
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         STOP: begin
            // Decided mid-stop-bit, so IDLE is back in time for a start bit that
            // follows immediately.
            if (wait_cnt == BIT_LAST) begin
               wait_nxt = '0;
`ifdef RECV_SERIAL_FRAME_ERR_EN
               if (rx_s) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
                  st_nxt    = IDLE;
               end else begin
                  ferr_nxt = 1'b1;
                  st_nxt   = BRK;
               end
`else
               data_nxt  = shift;
               valid_nxt = 1'b1;
               st_nxt    = IDLE;
`endif
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
`ifdef RECV_SERIAL_FRAME_ERR_EN
         BRK: begin
            // Hold off until the line returns high; a held-low line is one error.
            if (rx_s) begin
               st_nxt = IDLE;
            end
         end
`endif
         default: begin
            st_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         wait_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
`ifdef RECV_SERIAL_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
      end else begin
         st        <= st_nxt;
         wait_cnt  <= wait_nxt;
         bit_cnt   <= bit_nxt;
         shift     <= shift_nxt;
         data_out  <= data_nxt;
         valid     <= valid_nxt;
`ifdef RECV_SERIAL_FRAME_ERR_EN
         frame_err <= ferr_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_recv_serial.sv
// tb_recv_serial: directed bench for recv_serial with WAIT_DIV=8.
// A bit-accurate serial driver sends frames; a negedge monitor collects every
// valid strobe into a queue, which the directed steps compare against
// hand-computed bytes, counts and latency.
module tb_recv_serial;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_in = 1'b1;
   logic [7:0] data_out;
   logic       valid;
   logic       busy;
`ifdef RECV_SERIAL_FRAME_ERR_EN
   logic       frame_err;
`endif

   recv_serial #(.WAIT_DIV(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .data_out  (data_out),
      .valid     (valid),
      .busy      (busy)
`ifdef RECV_SERIAL_FRAME_ERR_EN
      ,
      .frame_err (frame_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         valid_cnt = 0;
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   int         last_valid_cyc = 0;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         valid_cnt      <= valid_cnt + 1;
         last_valid_cyc <= cyc;
         rx_q.push_back(data_out);
      end
`ifdef RECV_SERIAL_FRAME_ERR_EN
      if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (frame_err === 1'b1 && valid === 1'b1) both_cnt <= both_cnt + 1;
`endif
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      data_in = b;
      repeat (W) tick();
   endtask

   task automatic idle(input int n);
      data_in = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_b);
      data_in = 1'b1;
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      logic [31:0] got;
      got = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'hdead;
      check(tag, got, {24'd0, exp});
   endtask

   initial begin
      int base;
      int fbase;
      int t0;

      // Reset state
      rst = 1'b1;
      data_in = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_data_out", data_out, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      idle(4);

      // 1. Single byte 0x55 with latency and busy
      base = valid_cnt;
      t0 = cyc;
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (30) @(negedge clk);
            check("t1_busy_mid", busy, 1);
         end
      join
      idle(3 * W);
      check("t1_valid_cnt", valid_cnt, base + 1);
      check("t1_latency", last_valid_cyc - t0, 79);
      expect_byte("t1_byte", 8'h55);
      check("t1_data_out", data_out, 8'h55);
      check("t1_busy_end", busy, 0);

      // 2. Back-to-back 0x00, 0xFF
      base = valid_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(3 * W);
      check("t2_valid_cnt", valid_cnt, base + 2);
      expect_byte("t2_byte0", 8'h00);
      expect_byte("t2_byte1", 8'hFF);

      // 3. Two-cycle glitch: busy pulses, nothing delivered
      base = valid_cnt;
      fbase = ferr_cnt;
      data_in = 1'b0;
      tick();
      tick();
      data_in = 1'b1;
      tick();
      tick();
      check("t3_busy_glitch", busy, 1);
      idle(3 * W);
      check("t3_busy_end", busy, 0);
      check("t3_no_valid", valid_cnt, base);
      check("t3_no_ferr", ferr_cnt, fbase);
      check("t3_data_kept", data_out, 8'hFF);

      // 4. Bad stop bit on 0xA5
      base = valid_cnt;
      fbase = ferr_cnt;
      send_frame(8'hA5, 1'b0);
      idle(3 * W);
`ifdef RECV_SERIAL_FRAME_ERR_EN
      check("t4_ferr_cnt", ferr_cnt, fbase + 1);
      check("t4_no_valid", valid_cnt, base);
      check("t4_data_kept", data_out, 8'hFF);
`else
      check("t4_valid_cnt", valid_cnt, base + 1);
      expect_byte("t4_byte", 8'hA5);
      check("t4_data_out", data_out, 8'hA5);
`endif
      check("t4_busy_end", busy, 0);

      // 5. Reset mid-DATA of 0x3C, then a clean 0x3C
      base = valid_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(((8'h3C >> i) & 8'h01) != 0);
      data_in = 1'b1;
      repeat (3) tick();
      check("t5_busy_pre_rst", busy, 1);
      rst = 1'b1;
      tick();
      check("t5_busy_rst", busy, 0);
      check("t5_data_rst", data_out, 0);
      rst = 1'b0;
      idle(3 * W);
      check("t5_no_valid", valid_cnt, base);
      send_frame(8'h3C, 1'b1);
      idle(3 * W);
      check("t5_valid_cnt", valid_cnt, base + 1);
      expect_byte("t5_byte", 8'h3C);
      check("t5_data_out", data_out, 8'h3C);

      // 6. Loopback of all 256 byte values, back to back
      base = valid_cnt;
      for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
      idle(3 * W);
      check("t6_valid_cnt", valid_cnt, base + 256);
      for (int i = 0; i < 256; i++) expect_byte($sformatf("t6_byte_%0d", i), 8'(i));

      check("valid_ferr_overlap", both_cnt, 0);
      check("queue_empty", rx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
